dct_block_stager: RTL and testbench

Producer-side buffer for the 8-point DCT fetch port. Accepts a stream of signed 8-bit samples over a valid/ready handshake, packs every 8 consecutive samples into one bank of a two-bank (ping-pong) sample memory, and announces each completed bank to the DCT. The DCT then random-reads the bank via `fetch_addr`/`fetch_data` and releases it with `block_done`. The block sits between the pixel/row source and `loeffler_dct_8`, replacing the preloaded ROM used in unit testing.

---
 rtl/dct_block_stager_if.sv | 24 ++
 rtl/dct_block_stager.sv | 64 ++++++
 tb/tb_dct_block_stager.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_block_stager_if.sv
// Handshake, status and fetch-port signals between the sample source, the
// stager and the DCT consumer.
interface dct_block_stager_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  block_ready;
  logic                  block_done;
  logic [2:0]            fetch_addr;
  logic                  fetch_clk;
  logic [DATA_WIDTH-1:0] fetch_data;

  modport master (
    output in_valid, in_data, block_done, fetch_addr, fetch_clk,
    input  in_ready, block_ready, fetch_data
  );

  modport slave (
    input  in_valid, in_data, block_done, fetch_addr, fetch_clk,
    output in_ready, block_ready, fetch_data
  );
endinterface

// File: rtl/dct_block_stager.sv
// Ping-pong sample stager for the 8-point DCT: packs 8 samples per bank,
// announces complete banks and serves registered random reads until release.
module dct_block_stager #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_LEN  = 8
) (
  input logic              clock,
  input logic              nreset,
  dct_block_stager_if.slave bus
);
  localparam logic [2:0] LAST_IDX = 3'(BLOCK_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [16];
  logic [2:0]            wr_idx;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] fetch_q;
  logic                  in_ready;
  logic                  block_ready;
  logic                  accept;
  logic                  complete;
  logic                  rel;

  always_comb begin
    in_ready    = (count != 2'd2);
    block_ready = (count != 2'd0);
    accept      = bus.in_valid && in_ready;
    complete    = accept && (wr_idx == LAST_IDX);
    rel         = bus.block_done && block_ready;
  end

  assign bus.in_ready    = in_ready;
  assign bus.block_ready = block_ready;
  assign bus.fetch_data  = fetch_q;

  // Memory is deliberately left out of the reset domain: reset only discards banks.
  always_ff @(posedge clock) begin
    if (accept) mem[{wr_bank, wr_idx}] <= bus.in_data;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      count   <= '0;
      fetch_q <= '0;
    end else begin
      if (accept) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 3'd1;
      end
      if (complete) wr_bank <= ~wr_bank;
      if (rel)      rd_bank <= ~rd_bank;
      // Simultaneous completion and release leaves the bank count unchanged.
      unique case ({complete, rel})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (bus.fetch_clk) fetch_q <= mem[{rd_bank, bus.fetch_addr}];
    end
  end
endmodule

// File: tb/tb_dct_block_stager.sv
// Bench for dct_block_stager: queue-of-blocks reference model checked every
// cycle, plus directed scenarios with literal expected read-back values.
module tb_dct_block_stager;
  typedef logic [7:0] blk_t [8];

  logic clock;
  logic nreset;
  int   tests;
  int   fails;

  dct_block_stager_if #(.DATA_WIDTH(8)) bus ();

  dct_block_stager #(.DATA_WIDTH(8), .BLOCK_LEN(8)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: FIFO of completed blocks plus the block being filled.
  blk_t       banks[$];
  logic [7:0] part[$];
  logic [7:0] exp_fetch;
  bit         fetch_known;

  always @(posedge clock or negedge nreset) begin
    bit   full;
    bit   have;
    blk_t b;
    if (!nreset) begin
      banks.delete();
      part.delete();
      exp_fetch   = 8'h00;
      fetch_known = 1'b1;
    end else begin
      full = (banks.size() == 2);
      have = (banks.size() != 0);
      if (bus.fetch_clk) begin
        if (have) begin
          exp_fetch   = banks[0][bus.fetch_addr];
          fetch_known = 1'b1;
        end else begin
          fetch_known = 1'b0;
        end
      end
      if (bus.block_done && have) void'(banks.pop_front());
      if (bus.in_valid && !full) begin
        part.push_back(bus.in_data);
        if (part.size() == 8) begin
          foreach (b[i]) b[i] = part[i];
          banks.push_back(b);
          part.delete();
        end
      end
    end
  end

  always @(negedge clock) begin
    if (nreset) begin
      tests++;
      if (bus.in_ready !== (banks.size() != 2)) begin
        fails++;
        $display("FAIL model_in_ready t=%0t got=%b exp=%b", $time, bus.in_ready, banks.size() != 2);
      end
      tests++;
      if (bus.block_ready !== (banks.size() != 0)) begin
        fails++;
        $display("FAIL model_block_ready t=%0t got=%b exp=%b", $time, bus.block_ready, banks.size() != 0);
      end
      if (fetch_known) begin
        tests++;
        if (bus.fetch_data !== exp_fetch) begin
          fails++;
          $display("FAIL model_fetch_data t=%0t got=%h exp=%h", $time, bus.fetch_data, exp_fetch);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    bit acc;
    int budget;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    acc    = 1'b0;
    budget = 40;
    while (!acc && budget > 0) begin
      acc = bus.in_ready;
      tick();
      budget--;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout got=not_accepted exp=accepted value=%h", v);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus.fetch_clk  = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_clk  = 1'b0;
    d = bus.fetch_data;
  endtask

  task automatic done();
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
  endtask

  task automatic reset_mid();
    #2 nreset = 1'b0;
    #1;
    chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("rst_block_ready", {7'd0, bus.block_ready}, 8'd0);
    chk("rst_fetch_data", bus.fetch_data, 8'h00);
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic read_bank(input string name, input logic [7:0] base);
    logic [7:0] d;
    for (int unsigned i = 0; i < 8; i++) begin
      rd(3'(i), d);
      chk(name, d, base + 8'(i));
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] edge_vals [8];
    tests = 0;
    fails = 0;
    nreset = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.block_done = 1'b0;
    bus.fetch_addr = '0;
    bus.fetch_clk  = 1'b0;
    #23;
    chk("por_in_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("por_block_ready", {7'd0, bus.block_ready}, 8'd0);
    chk("por_fetch_data", bus.fetch_data, 8'h00);
    tick();
    nreset = 1'b1;
    tick();

    // Stream 1..8, block_ready one cycle after the 8th accept, ordered and random reads
    for (int unsigned i = 1; i <= 7; i++) send(8'(i));
    chk("pre8_block_ready", {7'd0, bus.block_ready}, 8'd0);
    send(8'd8);
    idle();
    chk("post8_block_ready", {7'd0, bus.block_ready}, 8'd1);
    read_bank("t1_seq", 8'd1);
    rd(3'd7, d); chk("t1_rd7", d, 8'd8);
    rd(3'd0, d); chk("t1_rd0", d, 8'd1);
    rd(3'd3, d); chk("t1_rd3", d, 8'd4);
    done();
    chk("t1_released", {7'd0, bus.block_ready}, 8'd0);

    // Fill both banks, hold sample 17 under backpressure, then release
    reset_mid();
    tick();
    for (int unsigned i = 1; i <= 16; i++) send(8'(i));
    idle();
    chk("t2_full_in_ready", {7'd0, bus.in_ready}, 8'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd17;
    tick(); tick(); tick();
    chk("t2_held_in_ready", {7'd0, bus.in_ready}, 8'd0);
    bus.block_done = 1'b1;
    tick();
    bus.block_done = 1'b0;
    chk("t2_rise_in_ready", {7'd0, bus.in_ready}, 8'd1);
    tick();
    idle();
    read_bank("t2_bank9", 8'd9);
    done();
    for (int unsigned i = 18; i <= 24; i++) send(8'(i));
    idle();
    rd(3'd0, d); chk("t2_held17", d, 8'd17);
    rd(3'd7, d); chk("t2_last24", d, 8'd24);
    done();

    // Continuous 1..24, release coincides with the 16th accept, reads overlap the stream
    reset_mid();
    tick();
    for (int unsigned i = 1; i <= 8; i++) send(8'(i));
    for (int unsigned i = 9; i <= 15; i++) begin
      bus.fetch_clk  = 1'b1;
      bus.fetch_addr = 3'(i - 9);
      send(8'(i));
      chk("t3_overlap_rd", bus.fetch_data, 8'(i - 8));
    end
    bus.fetch_addr = 3'd7;
    bus.block_done = 1'b1;
    send(8'd16);
    bus.block_done = 1'b0;
    bus.fetch_clk  = 1'b0;
    chk("t3_rel_edge_old_bank", bus.fetch_data, 8'd8);
    for (int unsigned i = 17; i <= 24; i++) send(8'(i));
    idle();
    read_bank("t3_bank9", 8'd9);
    done();
    read_bank("t3_bank17", 8'd17);
    done();

    // block_done with nothing ready is ignored
    reset_mid();
    tick();
    done();
    done();
    chk("t4_ignored_block_ready", {7'd0, bus.block_ready}, 8'd0);
    for (int unsigned i = 0; i < 8; i++) send(8'h40 + 8'(i));
    idle();
    read_bank("t4_bank", 8'h40);
    done();

    // Sign-boundary values pass through bit-exact
    edge_vals = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'hFE, 8'h81, 8'h55};
    for (int unsigned i = 0; i < 8; i++) send(edge_vals[i]);
    idle();
    for (int unsigned i = 0; i < 8; i++) begin
      rd(3'(i), d);
      chk("t5_edge_val", d, edge_vals[i]);
    end
    done();

    // Reset after 5 samples and after 12 samples
    for (int unsigned i = 1; i <= 5; i++) send(8'(i));
    idle();
    reset_mid();
    tick();
    for (int unsigned i = 0; i < 12; i++) send(8'h30 + 8'(i));
    idle();
    rd(3'd2, d); chk("t6_pre_reset_rd", d, 8'h32);
    reset_mid();
    tick();
    for (int unsigned i = 0; i < 8; i++) send(8'hA0 + 8'(i));
    idle();
    read_bank("t6_fresh", 8'hA0);
    done();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
